icache_repl_ctrl: RTL and testbench
===================================

// Module: icache_repl_ctrl
// PURPOSE
//  Refill/replacement sequencer for the 4-way instruction cache. On a lookup miss it picks
//  the victim way: lowest-index invalid way if any, else the replacement-policy way.
//  It then runs the line-refill handshake with memory, strobes the victim way's write
//  enable, and keeps per-set replacement state. Sits between the icache lookup stage and the
//  tag/data arrays.
// PARAMETERS
//  N_WAY   4   ways per set; only 4 is supported (2-bit way index)
//  N_SET   64  sets; SET_W = $clog2(N_SET)
//  LINE_W  26  line-address width sent to memory
// PORTS
//  clk_i         in   1       clock
//  rst_i         in   1       asynchronous reset, active-high
//  miss_i        in   1       lookup miss; sampled only in IDLE
//  miss_set_i    in   SET_W   set index of the miss
//  miss_line_i   in   LINE_W  line address of the miss
//  valid_i       in   4       valid bits of the addressed set, same cycle as miss_i
//  hit_i         in   1       lookup hit; touches replacement state
//  hit_set_i     in   SET_W   set index of the hit
//  hit_way_i     in   2       way that hit
//  flush_i       in   1       invalidate-all request (fence.i)
//  mem_req_o     out  1       refill request, held until granted
//  mem_addr_o    out  LINE_W  refill line address
//  mem_gnt_i     in   1       request accepted
//  mem_rvalid_i  in   1       refill data valid (single beat)
//  mem_err_i     in   1       bus error, qualified by mem_rvalid_i
//  way_we_o      out  4       one-hot tag/data/valid write enable for the victim way
//  fill_set_o    out  SET_W   set written by way_we_o
//  inval_all_o   out  1       one-cycle pulse: clear all valid bits
//  done_o        out  1       one-cycle pulse: refill written
//  err_o         out  1       one-cycle pulse: refill aborted on error
//  busy_o        out  1       high in every state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; replacement state=0; flush_pend=0; every output 0.
//  - All outputs are registered.
//  - FSM transitions:
//    - IDLE: flush_i or flush_pend -> FLUSH; flush has priority over miss_i.
//      Else miss_i -> REQ; latch set and line; latch victim =
//      (|~valid_i) ? trailing-zero index of ~valid_i : policy way of miss_set_i.
//    - REQ: mem_req_o=1, mem_addr_o=latched line. mem_gnt_i -> WAIT.
//      mem_req_o and mem_addr_o stay stable until the grant.
//    - WAIT: mem_rvalid_i & mem_err_i -> IDLE; err_o pulses; no write; no policy update.
//      mem_rvalid_i & ~mem_err_i -> FILL.
//    - FILL: way_we_o = 1<<victim, fill_set_o = set, done_o=1, each for exactly 1 cycle.
//      Touch the victim in replacement state; -> IDLE.
//    - FLUSH: inval_all_o=1 for 1 cycle; all replacement state cleared; flush_pend=0; -> IDLE.
//  - Latency, no memory stall:
//    - miss_i in cycle 0 -> mem_req_o in cycle 1.
//    - mem_rvalid_i in cycle n -> way_we_o in cycle n+1.
//  - miss_i while busy_o=1: ignored. The lookup stage stalls on busy_o.
//  - flush_i while busy: sets flush_pend. The refill completes first, or aborts on error;
//    FLUSH follows from IDLE.
//  - Hit touch: applied every cycle hit_i=1, in any state.
//    If a hit touch and a FILL touch hit the same set in the same cycle, the FILL touch wins.
//  - mem_gnt_i or mem_rvalid_i outside REQ/WAIT: ignored.
//  - Reset asserted mid-operation: immediate return to IDLE; mem_req_o drops asynchronously;
//    no way_we_o is issued.
// CONFIGURATION
//  ICACHE_PLRU_EN defined:
//   - Per-set 3-bit tree-PLRU {b2,b1,b0}.
//   - Victim: b0=0 ? (b1?1:0) : (b2?3:2).
//   - Touch way w: b0=~w[1]; if w[1]=0 then b1=~w[0], else b2=~w[0].
//  ICACHE_PLRU_EN undefined:
//   - A single global 2-bit round-robin counter is the policy way.
//   - It increments (wraps 3->0) on each FILL that used the policy.
//   - Hit touches are ignored; no per-set storage exists; FLUSH clears the counter.
// TESTING
//  1 Reset with miss_i=1 -> all outputs 0, busy_o=0; after release, IDLE.
//  2 Miss set 5, valid_i=4'b1011, line 0x123; gnt at cycle 2; rvalid at cycle 4
//    -> mem_req_o cycles 1-2, mem_addr_o=0x123, way_we_o=4'b0100 and done_o at cycle 5.
//  3 PLRU on, set 7, valid_i=4'hF:
//    miss -> way 0 filled; next miss -> way 2; hit way 3 then miss -> way 1.
//    PLRU off: fills go to ways 0,1,2,3,0.
//  4 rvalid with mem_err_i=1 -> err_o 1 cycle, way_we_o stays 0;
//    the next miss completes normally.
//  5 flush_i in WAIT -> fill completes (done_o); inval_all_o 2 cycles later;
//    next all-valid miss picks way 0.
//  6 rst_i asserted in REQ -> mem_req_o=0 before the next edge; state IDLE;
//    no way_we_o ever issued.

Source files
------------

// File: rtl/icache_repl_ctrl_if.sv
// Lookup/memory-side handshake bundle for the icache refill sequencer.
// master = lookup stage + memory + arrays, slave = icache_repl_ctrl.
`timescale 1ns/1ps
interface icache_repl_ctrl_if #(
   parameter int N_WAY  = 4,
   parameter int SET_W  = 6,
   parameter int LINE_W = 26
);
   logic              miss_i;
   logic [SET_W-1:0]  miss_set_i;
   logic [LINE_W-1:0] miss_line_i;
   logic [N_WAY-1:0]  valid_i;
   logic              hit_i;
   logic [SET_W-1:0]  hit_set_i;
   logic [1:0]        hit_way_i;
   logic              flush_i;
   logic              mem_req_o;
   logic [LINE_W-1:0] mem_addr_o;
   logic              mem_gnt_i;
   logic              mem_rvalid_i;
   logic              mem_err_i;
   logic [N_WAY-1:0]  way_we_o;
   logic [SET_W-1:0]  fill_set_o;
   logic              inval_all_o;
   logic              done_o;
   logic              err_o;
   logic              busy_o;

   modport master (
      output miss_i, miss_set_i, miss_line_i, valid_i, hit_i, hit_set_i, hit_way_i, flush_i,
             mem_gnt_i, mem_rvalid_i, mem_err_i,
      input  mem_req_o, mem_addr_o, way_we_o, fill_set_o, inval_all_o, done_o, err_o, busy_o
   );

   modport slave (
      input  miss_i, miss_set_i, miss_line_i, valid_i, hit_i, hit_set_i, hit_way_i, flush_i,
             mem_gnt_i, mem_rvalid_i, mem_err_i,
      output mem_req_o, mem_addr_o, way_we_o, fill_set_o, inval_all_o, done_o, err_o, busy_o
   );
endinterface

// File: rtl/icache_repl_ctrl.sv
// 4-way icache victim pick + refill sequencer; miss->req 1 cycle, rvalid->way_we 1 cycle, req held until gnt.
// ICACHE_PLRU_EN selects per-set tree-PLRU; default is one global round-robin counter.
`timescale 1ns/1ps
module icache_repl_ctrl #(
   parameter int N_WAY  = 4,
   parameter int N_SET  = 64,
   parameter int LINE_W = 26,
   localparam int SET_W = $clog2(N_SET)
) (
   input logic               clk_i,
   input logic               rst_i,
   icache_repl_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, FLUSH} state_t;

   state_t            state_q, state_d;
   logic [SET_W-1:0]  set_q;
   logic [LINE_W-1:0] line_q;
   logic [1:0]        victim_q;
   logic              flush_pend_q;
   logic [1:0]        inv_way, pol_way, victim_d;
   logic              any_inv;
   logic              miss_take;

   // Descending scan so the lowest-index invalid way is the one left standing.
   always_comb begin
      inv_way = 2'd0;
      any_inv = 1'b0;
      for (int i = N_WAY - 1; i >= 0; i--) begin
         if (!bus.valid_i[i]) begin
            inv_way = 2'(i);
            any_inv = 1'b1;
         end
      end
   end

   assign victim_d  = any_inv ? inv_way : pol_way;
   assign miss_take = (state_q == IDLE) && (state_d == REQ);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (bus.flush_i || flush_pend_q) state_d = FLUSH;
                else if (bus.miss_i)             state_d = REQ;
         REQ:   if (bus.mem_gnt_i)               state_d = WAIT;
         WAIT:  if (bus.mem_rvalid_i)            state_d = bus.mem_err_i ? IDLE : FILL;
         FILL:  state_d = IDLE;
         FLUSH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= IDLE;
         set_q           <= '0;
         line_q          <= '0;
         victim_q        <= 2'd0;
         flush_pend_q    <= 1'b0;
         bus.mem_req_o   <= 1'b0;
         bus.mem_addr_o  <= '0;
         bus.way_we_o    <= '0;
         bus.fill_set_o  <= '0;
         bus.inval_all_o <= 1'b0;
         bus.done_o      <= 1'b0;
         bus.err_o       <= 1'b0;
         bus.busy_o      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (miss_take) begin
            set_q    <= bus.miss_set_i;
            line_q   <= bus.miss_line_i;
            victim_q <= victim_d;
         end
         // A flush arriving during FLUSH itself is kept pending rather than lost.
         if (state_q == FLUSH)                  flush_pend_q <= 1'b0;
         if (bus.flush_i && (state_q != IDLE))  flush_pend_q <= 1'b1;
         bus.mem_req_o   <= (state_d == REQ);
         bus.mem_addr_o  <= (state_d == REQ) ? (miss_take ? bus.miss_line_i : line_q) : '0;
         bus.way_we_o    <= (state_d == FILL) ? (N_WAY'(1) << victim_q) : '0;
         bus.fill_set_o  <= (state_d == FILL) ? set_q : '0;
         bus.done_o      <= (state_d == FILL);
         bus.err_o       <= (state_q == WAIT) && bus.mem_rvalid_i && bus.mem_err_i;
         bus.inval_all_o <= (state_d == FLUSH);
         bus.busy_o      <= (state_d != IDLE);
      end
   end

`ifdef ICACHE_PLRU_EN
   logic [2:0] plru_q [N_SET];
   logic [2:0] plru_cur;

   function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
      plru_touch    = b;
      plru_touch[0] = ~w[1];
      if (w[1]) plru_touch[2] = ~w[0];
      else      plru_touch[1] = ~w[0];
   endfunction

   assign plru_cur = plru_q[bus.miss_set_i];
   assign pol_way  = {plru_cur[0], plru_cur[0] ? plru_cur[2] : plru_cur[1]};

   // Fill touch is written last so it overrides a same-set hit touch.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < N_SET; s++) plru_q[s] <= 3'b000;
      end else if (state_q == FLUSH) begin
         for (int s = 0; s < N_SET; s++) plru_q[s] <= 3'b000;
      end else begin
         if (bus.hit_i)
            plru_q[bus.hit_set_i] <= plru_touch(plru_q[bus.hit_set_i], bus.hit_way_i);
         if (state_q == FILL)
            plru_q[set_q] <= plru_touch(plru_q[set_q], victim_q);
      end
   end
`else
   logic [1:0] rr_q;
   logic       pol_used_q;

   assign pol_way = rr_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q       <= 2'd0;
         pol_used_q <= 1'b0;
      end else begin
         if (miss_take)                          pol_used_q <= ~any_inv;
         if (state_q == FLUSH)                   rr_q <= 2'd0;
         else if ((state_q == FILL) && pol_used_q) rr_q <= rr_q + 2'd1;
      end
   end
`endif
endmodule

// File: tb/tb_icache_repl_ctrl.sv
// Randomised scoreboard bench for icache_repl_ctrl with a transaction-level replacement model.
`timescale 1ns/1ps
module tb_icache_repl_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   icache_repl_ctrl_if #(.N_WAY(4), .SET_W(6), .LINE_W(26)) bus ();
   icache_repl_ctrl #(.N_WAY(4), .N_SET(64), .LINE_W(26)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   typedef enum int {EV_REQ, EV_FILL, EV_ERR, EV_FLUSH} ev_t;
   typedef struct {ev_t kind; logic [25:0] addr; logic [3:0] we; logic [5:0] set;} exp_t;

   exp_t sb[$];
   int   errors = 0, checks = 0, cycle = 0, done_cyc = 0, inval_cyc = 0;
   bit   req_prev = 1'b0;

   // Reference replacement state: round-robin count, or the three PLRU bits per set.
   int rr = 0;
   bit b0[64], b1[64], b2[64];

   always @(posedge clk) cycle++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int policy_way(input int s);
`ifdef ICACHE_PLRU_EN
      if (!b0[s]) return b1[s] ? 1 : 0;
      return b2[s] ? 3 : 2;
`else
      return (s >= 0) ? rr : 0;
`endif
   endfunction

   task automatic touch(input int s, input int w);
`ifdef ICACHE_PLRU_EN
      b0[s] = (w < 2);
      if (w < 2) b1[s] = (w == 0);
      else       b2[s] = (w == 2);
`else
      if (s < 0 || w < 0) rr = rr;
`endif
   endtask

   task automatic model_clear();
      rr = 0;
      for (int s = 0; s < 64; s++) begin
         b0[s] = 1'b0; b1[s] = 1'b0; b2[s] = 1'b0;
      end
   endtask

   task automatic pop_exp(input ev_t k, output exp_t e, output bit ok);
      e = '{EV_REQ, 26'd0, 4'd0, 6'd0};
      ok = 1'b0;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_unexpected: event %0d seen, queue empty (t=%0t)", k, $time);
      end else begin
         e = sb.pop_front();
         chk("sb_kind", k, e.kind);
         ok = (e.kind == k);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      bit   ok;
      if (rst) begin
         req_prev = 1'b0;
      end else begin
         if (bus.mem_req_o && !req_prev) begin
            pop_exp(EV_REQ, e, ok);
            if (ok) chk("sb_addr", bus.mem_addr_o, e.addr);
         end
         if (bus.done_o) begin
            pop_exp(EV_FILL, e, ok);
            if (ok) begin
               chk("sb_we", bus.way_we_o, e.we);
               chk("sb_set", bus.fill_set_o, e.set);
            end
            done_cyc = cycle;
         end else if (bus.way_we_o != 4'd0) begin
            chk("stray_we", bus.way_we_o, 4'd0);
         end
         if (bus.err_o) begin
            pop_exp(EV_ERR, e, ok);
            if (ok) chk("sb_err_we", bus.way_we_o, 4'd0);
         end
         if (bus.inval_all_o) begin
            pop_exp(EV_FLUSH, e, ok);
            inval_cyc = cycle;
         end
         req_prev = bus.mem_req_o;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (bus.busy_o && n < 50) begin
         cyc();
         n++;
      end
      if (bus.busy_o) chk("idle_timeout", bus.busy_o, 1'b0);
   endtask

   task automatic do_hit(input logic [5:0] s, input logic [1:0] w);
      bus.hit_i = 1'b1; bus.hit_set_i = s; bus.hit_way_i = w;
      touch(s, w);
      cyc();
      bus.hit_i = 1'b0;
   endtask

   task automatic do_flush();
      exp_t e;
      wait_idle();
      e = '{EV_FLUSH, 26'd0, 4'd0, 6'd0};
      sb.push_back(e);
      bus.flush_i = 1'b1;
      cyc();
      bus.flush_i = 1'b0;
      chk("flush_inval", bus.inval_all_o, 1'b1);
      model_clear();
      cyc();
   endtask

   task automatic do_miss(input logic [5:0] s, input logic [25:0] ln, input logic [3:0] v,
                          input int gd, input int rd, input bit er, input bit fl,
                          input bit hf, input logic [5:0] hs, input logic [1:0] hw,
                          output logic [3:0] got_we);
      int vic;
      bit usep;
      logic [3:0] exp_we;
      exp_t e;
      wait_idle();
      usep = (v == 4'hF);
      vic = 0;
      if (usep) vic = policy_way(s);
      else while (v[vic]) vic++;
      exp_we = er ? 4'd0 : 4'(1 << vic);
      e = '{EV_REQ, ln, 4'd0, 6'd0};
      sb.push_back(e);
      bus.miss_i = 1'b1; bus.miss_set_i = s; bus.miss_line_i = ln; bus.valid_i = v;
      cyc();
      bus.miss_i = 1'b0; bus.miss_line_i = 26'($urandom); bus.valid_i = 4'($urandom);
      chk("req_lat", {bus.mem_req_o, bus.mem_addr_o}, {1'b1, ln});
      for (int i = 0; i < gd; i++) begin
         bus.mem_rvalid_i = 1'($urandom_range(0, 1));
         cyc();
         chk("req_hold", {bus.mem_req_o, bus.mem_addr_o}, {1'b1, ln});
      end
      bus.mem_rvalid_i = 1'b0;
      bus.mem_gnt_i = 1'b1;
      cyc();
      bus.mem_gnt_i = 1'b0;
      chk("req_drop", bus.mem_req_o, 1'b0);
      bus.flush_i = fl;
      for (int i = 0; i < rd; i++) begin
         cyc();
         bus.flush_i = 1'b0;
      end
      e = '{er ? EV_ERR : EV_FILL, 26'd0, exp_we, s};
      sb.push_back(e);
      if (fl) begin
         e.kind = EV_FLUSH;
         sb.push_back(e);
      end
      bus.mem_rvalid_i = 1'b1; bus.mem_err_i = er;
      cyc();
      bus.mem_rvalid_i = 1'b0; bus.mem_err_i = 1'b0; bus.flush_i = 1'b0;
      got_we = bus.way_we_o;
      chk("fill_lat", {bus.done_o, bus.err_o, bus.way_we_o}, {~er, er, exp_we});
      if (!er) begin
         if (hf) begin
            bus.hit_i = 1'b1; bus.hit_set_i = hs; bus.hit_way_i = hw;
            touch(hs, hw);
         end
         touch(s, vic);
         if (usep) rr = (rr + 1) % 4;
         cyc();
         bus.hit_i = 1'b0;
      end
      if (fl) begin
         model_clear();
         repeat (2) cyc();
      end
   endtask

   logic [3:0] got;
   logic [3:0] exp3[5];
   int         n3;

   initial begin
      exp_t e;
      rst = 1'b1;
      bus.miss_i = 1'b1; bus.miss_set_i = '0; bus.miss_line_i = '0; bus.valid_i = '0;
      bus.hit_i = 1'b0; bus.hit_set_i = '0; bus.hit_way_i = '0; bus.flush_i = 1'b0;
      bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_err_i = 1'b0;
      model_clear();

      // Reset held with a miss pending.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", {bus.mem_req_o, bus.mem_addr_o, bus.way_we_o, bus.fill_set_o,
                       bus.inval_all_o, bus.done_o, bus.err_o}, 64'd0);
      chk("rst_busy", bus.busy_o, 1'b0);
      rst = 1'b0; bus.miss_i = 1'b0;
      cyc();
      chk("post_rst_idle", {bus.busy_o, bus.mem_req_o}, 2'b00);

      // Basic refill: set 5, one invalid way (2), gnt at cycle 2, rvalid at cycle 4.
      do_miss(6'd5, 26'h123, 4'b1011, 1, 1, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, got);
      chk("basic_way2", got, 4'b0100);

      // Policy sequence on an all-valid set from a cleared state.
      do_flush();
`ifdef ICACHE_PLRU_EN
      exp3 = '{4'b0001, 4'b0100, 4'b0010, 4'b0000, 4'b0000};
      n3 = 3;
`else
      exp3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      n3 = 5;
`endif
      for (int i = 0; i < n3; i++) begin
         if (i == 2) do_hit(6'd7, 2'd3);
         do_miss(6'd7, 26'($urandom), 4'hF, 0, 0, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, got);
         chk("policy_seq", got, exp3[i]);
      end

      // Bus error aborts the refill; next miss completes.
      do_miss(6'd11, 26'h3ABCDEF, 4'hF, 0, 1, 1'b1, 1'b0, 1'b0, 6'd0, 2'd0, got);
      cyc();
      chk("err_pulse_once", {bus.err_o, bus.way_we_o}, 5'd0);
      do_miss(6'd11, 26'h0000BEE, 4'hF, 2, 0, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, got);

      // Flush during WAIT: fill first, invalidate two cycles later, then way 0.
      do_miss(6'd9, 26'h155, 4'b0111, 0, 2, 1'b0, 1'b1, 1'b0, 6'd0, 2'd0, got);
      chk("flush_gap", inval_cyc - done_cyc, 2);
      do_miss(6'd20, 26'h2AA, 4'hF, 0, 0, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, got);
      chk("flush_then_way0", got, 4'b0001);

      // Fill touch beats a same-cycle hit touch on the same set.
      do_miss(6'd3, 26'h77, 4'hF, 0, 0, 1'b0, 1'b0, 1'b1, 6'd3, 2'd1, got);
      do_miss(6'd3, 26'h78, 4'hF, 1, 1, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, got);

      // Reset while requesting.
      wait_idle();
      e = '{EV_REQ, 26'h0DD, 4'd0, 6'd0};
      sb.push_back(e);
      bus.miss_i = 1'b1; bus.miss_set_i = 6'd2; bus.miss_line_i = 26'h0DD; bus.valid_i = 4'hF;
      cyc();
      bus.miss_i = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_async_req", {bus.mem_req_o, bus.busy_o}, 2'b00);
      bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      model_clear();
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("rst_idle_ignore", {bus.busy_o, bus.way_we_o}, 5'd0);
      end
      bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
      chk("rst_sb_empty", sb.size(), 0);

      // Randomised traffic.
      for (int t = 0; t < 80; t++) begin
         logic [5:0] s;
         logic [3:0] v;
         s = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
         v = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
         do_miss(s, 26'($urandom), v, $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 1) ? s : 6'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), got);
         if ($urandom_range(0, 3) == 0) begin
            wait_idle();
            do_hit(6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
         end
         if ($urandom_range(0, 15) == 0) do_flush();
      end

      wait_idle();
      repeat (3) cyc();
      chk("sb_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
